// File: rtl/r2_dif_butterfly_stage.sv
// Radix-2 DIF butterfly stage: buffers the first half of each frame, then emits (a+b, a-b) pairs.
// Optional define BFLY_SCALE_EN halves both lanes with round-half-up to stop growth across stages.
module r2_dif_butterfly_stage #(
    parameter int IN_W  = 10,
    parameter int OUT_W = IN_W + 1,
    parameter int N     = 32
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [IN_W-1:0]  i_data,
    input  logic             in_valid,
    output logic [OUT_W-1:0] o_up,
    output logic [OUT_W-1:0] o_down,
    output logic             out_valid,
    output logic             out_last
);
    localparam int AW   = $clog2(N);
    localparam int HALF = N / 2;

    logic [AW-1:0]          cnt;
    logic signed [IN_W-1:0] mem [HALF];
    logic                   is_pair;
    logic [AW-2:0]          slot;
    logic signed [IN_W-1:0] a;
    logic signed [IN_W-1:0] b;
    logic signed [OUT_W-1:0] up_w;
    logic signed [OUT_W-1:0] dn_w;

    // The MSB of the sample counter is the FILL/PAIR phase; the low bits are the slot.
    assign is_pair = cnt[AW-1];
    assign slot    = cnt[AW-2:0];
    assign a       = mem[slot];
    assign b       = $signed(i_data);

`ifdef BFLY_SCALE_EN
    logic signed [IN_W+1:0] up_full;
    logic signed [IN_W+1:0] dn_full;

    // Extra headroom bit absorbs the rounding +1 before the arithmetic shift.
    always_comb begin
        up_full = (IN_W+2)'(a) + (IN_W+2)'(b) + (IN_W+2)'(1);
        dn_full = (IN_W+2)'(a) - (IN_W+2)'(b) + (IN_W+2)'(1);
        up_w    = OUT_W'($signed(up_full[IN_W+1:1]));
        dn_w    = OUT_W'($signed(dn_full[IN_W+1:1]));
    end
`else
    always_comb begin
        up_w = OUT_W'(a) + OUT_W'(b);
        dn_w = OUT_W'(a) - OUT_W'(b);
    end
`endif

    // NOTE: the delay memory has no reset; its contents are always overwritten by FILL before PAIR reads them.
    always_ff @(posedge clk) begin
        if (in_valid && !is_pair)
            mem[slot] <= b;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt       <= '0;
            o_up      <= '0;
            o_down    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (in_valid) begin
                cnt <= cnt + 1'b1;
                if (is_pair) begin
                    o_up      <= up_w;
                    o_down    <= dn_w;
                    out_valid <= 1'b1;
                    out_last  <= (cnt == AW'(N - 1));
                end
            end
        end
    end
endmodule

// File: tb/tb_r2_dif_butterfly_stage.sv
// Scoreboard bench for r2_dif_butterfly_stage (N=32, IN_W=10); honours BFLY_SCALE_EN when defined.
module tb_r2_dif_butterfly_stage;
    localparam int IN_W  = 10;
    localparam int OUT_W = 11;
    localparam int N     = 32;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [IN_W-1:0]  i_data;
    logic             in_valid;
    logic [OUT_W-1:0] o_up;
    logic [OUT_W-1:0] o_down;
    logic             out_valid;
    logic             out_last;

    r2_dif_butterfly_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N)) dut (
        .clk(clk), .i_rst(i_rst), .i_data(i_data), .in_valid(in_valid),
        .o_up(o_up), .o_down(o_down), .out_valid(out_valid), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int up;
        int dn;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;
    int   n_last   = 0;
    int   idx      = 0;
    int   shadow [N/2];
    bit   mon_en   = 0;
    bit   gap_mode = 0;
    bit   prev_valid = 0;
    bit   prev_rst   = 1;
    int   last_up  = 0;
    int   last_dn  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_up(input int av, input int bv);
`ifdef BFLY_SCALE_EN
        return (av + bv + 1) >>> 1;
`else
        return av + bv;
`endif
    endfunction

    function automatic int exp_dn(input int av, input int bv);
`ifdef BFLY_SCALE_EN
        return (av - bv + 1) >>> 1;
`else
        return av - bv;
`endif
    endfunction

    function automatic void push(input int up, input int dn, input bit last);
        exp_t e;
        e.up = up;
        e.dn = dn;
        e.last = last;
        exp_q.push_back(e);
    endfunction

    // Drives one accepted sample; auto_exp lets the model predict the pair, otherwise the caller pushed it.
    task automatic send_sample(input int d, input bit gap, input bit auto_exp);
        if (idx < N/2)
            shadow[idx] = d;
        else if (auto_exp)
            push(exp_up(shadow[idx-N/2], d), exp_dn(shadow[idx-N/2], d), idx == N-1);
        i_data   = d[IN_W-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idx = (idx + 1) % N;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check({name, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_up"},    int'($signed(o_up)), 0);
        check({name, "_down"},  int'($signed(o_down)), 0);
        check({name, "_valid"}, int'(out_valid), 0);
        check({name, "_last"},  int'(out_last), 0);
    endtask

    // Monitor: pops the scoreboard on every valid pair, checks hold behaviour when idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (i_rst || prev_rst) begin
                last_up = int'($signed(o_up));
                last_dn = int'($signed(o_down));
            end else if (out_valid) begin
                exp_t e;
                n_valid++;
                if (out_last) n_last++;
                if (gap_mode) check("no_back_to_back_valid", int'(prev_valid), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pair: got up=%0d down=%0d, expected no output (t=%0t)",
                             $signed(o_up), $signed(o_down), $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pair_up",   int'($signed(o_up)), e.up);
                    check("pair_down", int'($signed(o_down)), e.dn);
                    check("pair_last", int'(out_last), int'(e.last));
                end
                last_up = int'($signed(o_up));
                last_dn = int'($signed(o_down));
            end else begin
                check("idle_hold_up",   int'($signed(o_up)), last_up);
                check("idle_hold_down", int'($signed(o_down)), last_dn);
                check("idle_last_low",  int'(out_last), 0);
            end
            prev_valid = out_valid;
            prev_rst   = i_rst;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int l0;
        i_rst    = 1'b1;
        in_valid = 1'b0;
        i_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        check_reset_state("reset");
        mon_en = 1;

        // Ramp 0..31, continuous
        v0 = n_valid; l0 = n_last;
        for (int k = 0; k < N; k++) send_sample(k, 1'b0, 1'b1);
        drain("ramp");
        check("ramp_valid_count", n_valid - v0, 16);
        check("ramp_last_count",  n_last - l0, 1);

        // Extremes with hand-computed results
        for (int k = 0; k < N/2; k++) send_sample(-512, 1'b0, 1'b0);
        for (int k = 0; k < N/2; k++) begin
`ifdef BFLY_SCALE_EN
            push(-512, 0, k == N/2-1);
`else
            push(-1024, 0, k == N/2-1);
`endif
            send_sample(-512, 1'b0, 1'b0);
        end
        drain("ext_neg");
        for (int k = 0; k < N/2; k++) send_sample(511, 1'b0, 1'b0);
        for (int k = 0; k < N/2; k++) begin
`ifdef BFLY_SCALE_EN
            push(0, 512, k == N/2-1);
`else
            push(-1, 1023, k == N/2-1);
`endif
            send_sample(-512, 1'b0, 1'b0);
        end
        drain("ext_mix");

        // Ramp with in_valid toggling every cycle
        v0 = n_valid;
        gap_mode = 1;
        for (int k = 0; k < N; k++) send_sample(k, 1'b1, 1'b1);
        drain("gaps");
        gap_mode = 0;
        check("gaps_valid_count", n_valid - v0, 16);

        // Reset mid-frame: pairs from samples 16..19 emerge before reset, nothing afterwards
        for (int k = 0; k < 20; k++) send_sample(k, 1'b0, 1'b1);
        drain("pre_reset");
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        idx = 0;
        check_reset_state("mid_reset");
        v0 = n_valid;
`ifdef BFLY_SCALE_EN
        push(108, -8, 1'b0);
`else
        push(216, -16, 1'b0);
`endif
        for (int k = 0; k < N; k++) send_sample(100 + k, 1'b0, k != N/2);
        drain("after_reset");
        check("after_reset_valid_count", n_valid - v0, 16);

        // Back-to-back frames 0..63
        v0 = n_valid; l0 = n_last;
        for (int k = 0; k < 2*N; k++) send_sample(k, 1'b0, 1'b1);
        drain("b2b");
        check("b2b_valid_count", n_valid - v0, 32);
        check("b2b_last_count",  n_last - l0, 2);

        // Rounding corner vectors: (a,b) = (3,2), (-3,0), (-512,-512), rest zero
        for (int k = 0; k < N/2; k++)
            send_sample((k == 0) ? 3 : (k == 1) ? -3 : (k == 2) ? -512 : 0, 1'b0, 1'b0);
        for (int k = 0; k < N/2; k++) begin
`ifdef BFLY_SCALE_EN
            if (k == 0)      push(3, 1, 1'b0);
            else if (k == 1) push(-1, -1, 1'b0);
            else if (k == 2) push(-512, 0, 1'b0);
            else             push(0, 0, k == N/2-1);
`else
            if (k == 0)      push(5, 1, 1'b0);
            else if (k == 1) push(-3, -3, 1'b0);
            else if (k == 2) push(-1024, 0, 1'b0);
            else             push(0, 0, k == N/2-1);
`endif
            send_sample((k == 0) ? 2 : (k == 2) ? -512 : 0, 1'b0, 1'b0);
        end
        drain("round");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
